// File: rtl/cpa_rr_scheduler.sv
// Round-robin scheduler that shares one Kogge-Stone adder among NUM_REQ requesters.
// Result appears 2 cycles after the grant cycle; holds 2 items max under backpressure, then stalls grants.

module kogge_stone_adder #(
   parameter int BIT_LEN = 16
) (
   input  logic [BIT_LEN-1:0] a,
   input  logic [BIT_LEN-1:0] b,
   output logic [BIT_LEN:0]   sum
);
   localparam int LVL = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;

   logic [BIT_LEN-1:0] p0;
   logic [BIT_LEN-1:0] gc;
   logic [BIT_LEN-1:0] pc;
   logic [BIT_LEN-1:0] gn;
   logic [BIT_LEN-1:0] pn;

   // gc[i] ends up as the carry out of bit i (group generate over bits 0..i)
   always_comb begin
      p0 = a ^ b;
      gc = a & b;
      pc = p0;
      gn = '0;
      pn = '0;
      for (int l = 0; l < LVL; l++) begin
         for (int i = 0; i < BIT_LEN; i++) begin
            if (i >= (1 << l)) begin
               gn[i] = gc[i] | (pc[i] & gc[(i >= (1 << l)) ? i - (1 << l) : 0]);
               pn[i] = pc[i] & pc[(i >= (1 << l)) ? i - (1 << l) : 0];
            end else begin
               gn[i] = gc[i];
               pn[i] = pc[i];
            end
         end
         gc = gn;
         pc = pn;
      end
      sum = {gc[BIT_LEN-1], p0 ^ {gc[BIT_LEN-2:0], 1'b0}};
   end
endmodule

module cpa_rr_scheduler #(
   parameter  int NUM_REQ = 4,
   parameter  int BIT_LEN = 16,
   localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*BIT_LEN-1:0] req_a,
   input  logic [NUM_REQ*BIT_LEN-1:0] req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [BIT_LEN:0]           rsp_sum,
   output logic [ID_W-1:0]            rsp_id,
   output logic                       busy
);
   logic [ID_W-1:0]    ptr;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;

   logic               s1_valid;
   logic [BIT_LEN-1:0] s1_a;
   logic [BIT_LEN-1:0] s1_b;
   logic [ID_W-1:0]    s1_id;

   logic               s2_valid;
   logic [BIT_LEN:0]   s2_sum;
   logic [ID_W-1:0]    s2_id;

   logic               s2_load;
   logic               s1_free;
   logic [BIT_LEN:0]   add_sum;

   assign s2_load = s1_valid && (!s2_valid || rsp_ready);
   assign s1_free = !s1_valid || s2_load;

   // First valid requester at or after the pointer, wrapping
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && s1_free && grant_vld)
         req_ready[grant_id] = 1'b1;
   end

   kogge_stone_adder #(.BIT_LEN(BIT_LEN)) u_adder (
      .a   (s1_a),
      .b   (s1_b),
      .sum (add_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         ptr      <= '0;
      end else begin
         if (s2_load) begin
            s2_valid <= 1'b1;
            s2_sum   <= add_sum;
            s2_id    <= s1_id;
         end else if (rsp_ready) begin
            s2_valid <= 1'b0;
         end

         if (s1_free) begin
            s1_valid <= grant_vld;
            if (grant_vld) begin
               s1_a  <= req_a[int'(grant_id)*BIT_LEN +: BIT_LEN];
               s1_b  <= req_b[int'(grant_id)*BIT_LEN +: BIT_LEN];
               s1_id <= grant_id;
               ptr   <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
            end
         end
      end
   end

   assign rsp_valid = s2_valid;
   assign rsp_sum   = s2_sum;
   assign rsp_id    = s2_id;
   assign busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_cpa_rr_scheduler.sv
// Directed bench for cpa_rr_scheduler: latency, carry boundaries, fairness, backpressure, reset.
`timescale 1ns/1ps
module tb_cpa_rr_scheduler;
   localparam int NUM_REQ = 4;
   localparam int BIT_LEN = 16;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*BIT_LEN-1:0] req_a;
   logic [NUM_REQ*BIT_LEN-1:0] req_b;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [BIT_LEN:0]           rsp_sum;
   logic [1:0]                 rsp_id;
   logic                       busy;

   int n_checks = 0;
   int n_errors = 0;

   cpa_rr_scheduler #(.NUM_REQ(NUM_REQ), .BIT_LEN(BIT_LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2ns after the rising edge; checks happen 1ns later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*BIT_LEN +: BIT_LEN] = a;
      req_b[i*BIT_LEN +: BIT_LEN] = b;
   endtask

   task automatic single_op(input string tag, input int i, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] exp_sum);
      set_req(i, a, b);
      req_valid = 4'b0001 << i;
      #1 chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << i));
      tick();
      req_valid = '0;
      #1 chk({tag, "_lat1_vld"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_lat1_busy"}, 32'(busy), 32'd1);
      tick();
      #1 chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_sum"}, 32'(rsp_sum), exp_sum);
      chk({tag, "_id"}, 32'(rsp_id), 32'(i));
      tick();
      #1 chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_drain"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      #1 chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Round-robin: all valid for 8 grant cycles
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 16'(i * 16'h1111), 16'(16'h0100 + i));
      req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         if (k < 8) chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            chk("rr_vld", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'((k - 2) % 4));
            chk("rr_sum", 32'(rsp_sum), 32'(((k - 2) % 4) * 32'h1111 + 32'h100 + (k - 2) % 4));
         end
         tick();
      end
      #1 chk("rr_idle", 32'(busy), 32'd0);

      single_op("single", 2, 16'h1234, 16'h0F0F, 32'h02143);
      single_op("carry",  0, 16'hFFFF, 16'h0001, 32'h10000);
      single_op("max",    1, 16'hFFFF, 16'hFFFF, 32'h1FFFE);
      single_op("zero",   2, 16'h0000, 16'h0000, 32'h00000);

      // Pointer at 3, only 1 and 3 valid
      set_req(1, 16'h0011, 16'h0001);
      set_req(3, 16'h0033, 16'h0003);
      req_valid = 4'b1010;
      #1 chk("wrap_first", 32'(req_ready), 32'b1000);
      tick();
      #1 chk("wrap_second", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      #1 chk("wrap_id0", 32'(rsp_id), 32'd3);
      chk("wrap_sum0", 32'(rsp_sum), 32'h36);
      tick();
      #1 chk("wrap_id1", 32'(rsp_id), 32'd1);
      chk("wrap_sum1", 32'(rsp_sum), 32'h12);
      req_valid = 4'hF;
      #1 chk("wrap_ptr", 32'(req_ready), 32'b0100);
      req_valid = '0;
      tick();
      #1 chk("wrap_idle", 32'(busy), 32'd0);

      // Backpressure: pointer at 2, requesters 0 and 1 valid
      rsp_ready = 1'b0;
      set_req(0, 16'h0005, 16'h0007);
      set_req(1, 16'h8000, 16'h8001);
      req_valid = 4'b0011;
      #1 chk("bp_g0", 32'(req_ready), 32'b0001);
      tick();
      #1 chk("bp_g1", 32'(req_ready), 32'b0010);
      tick();
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_vld", 32'(rsp_valid), 32'd1);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_sum", 32'(rsp_sum), 32'h0000C);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      #1 chk("bp_out0", 32'(rsp_id), 32'd0);
      tick();
      #1 chk("bp_out1_vld", 32'(rsp_valid), 32'd1);
      chk("bp_out1_id", 32'(rsp_id), 32'd1);
      chk("bp_out1_sum", 32'(rsp_sum), 32'h10001);
      tick();
      #1 chk("bp_done_vld", 32'(rsp_valid), 32'd0);
      chk("bp_done_busy", 32'(busy), 32'd0);

      // Reset while both stages hold data (pointer at 2 beforehand)
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      tick();
      tick();
      req_valid = '0;
      #1 chk("mid_full", 32'(rsp_valid & busy), 32'd1);
      rst_n = 1'b0;
      tick();
      #1 chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      set_req(1, 16'h0100, 16'h0200);
      req_valid = 4'b0110;
      #1 chk("post_rst_grant", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      tick();
      #1 chk("post_rst_id", 32'(rsp_id), 32'd1);
      chk("post_rst_sum", 32'(rsp_sum), 32'h00300);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
